// File: rtl/clock_pkg.sv
// Shared constants and types for the clock-setting button front end.
// Timing defaults assume the 50 MHz system clock.
package clock_pkg;

    typedef enum logic [1:0] {
        HOLD_IDLE,
        HOLD_DELAY,
        HOLD_REPEAT
    } hold_state_t;

    localparam int unsigned CLK_HZ                = 50_000_000;
    localparam int unsigned DEBOUNCE_CYCLES_DEF   = 1_000_000;
    localparam int unsigned REPEAT_DELAY_DEF      = 25_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF     = 5_000_000;

    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned max2(input int unsigned a,
                                         input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_channel.sv
// One button: 2-flop synchronizer, debounce counter and hold/auto-repeat FSM.
// All outputs are registered.
module button_channel
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_raw,
    input  logic repeat_en,
    output logic btn_level,
    output logic btn_step,
    output logic btn_release
);

    localparam int unsigned DW = cnt_width(DEBOUNCE_CYCLES);
    localparam int unsigned HW = cnt_width(max2(REPEAT_DELAY, REPEAT_PERIOD));
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] RD_LAST  = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RP_LAST  = HW'(REPEAT_PERIOD - 1);

    logic [1:0]    sync_q;
    logic [DW-1:0] deb_cnt;
    logic          level_q;
    logic          differ;
    logic          toggle;
    logic          rise;
    logic          fall;

    hold_state_t   state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          step_q, step_d;
    logic          rel_q, rel_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
        end
    end

    assign differ = sync_q[1] ^ level_q;
    assign toggle = differ && (deb_cnt == DEB_LAST);
    assign rise   = toggle && !level_q;
    assign fall   = toggle && level_q;

    // Any agreement with the accepted level restarts the stability window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_cnt <= '0;
            level_q <= 1'b0;
        end else begin
            level_q <= level_q ^ toggle;
            if (!differ || toggle) begin
                deb_cnt <= '0;
            end else if (deb_cnt != '1) begin
                deb_cnt <= deb_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HOLD_IDLE;
            hold_q  <= '0;
            step_q  <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            step_q  <= step_d;
            rel_q   <= rel_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        step_d  = 1'b0;
        rel_d   = 1'b0;
        if (fall) begin
            state_d = HOLD_IDLE;
            hold_d  = '0;
            rel_d   = 1'b1;
        end else begin
            unique case (state_q)
                HOLD_IDLE: begin
                    if (rise) begin
                        state_d = HOLD_DELAY;
                        hold_d  = '0;
                        step_d  = 1'b1;
                    end
                end
                HOLD_DELAY: begin
                    if (repeat_en) begin
                        if (hold_q == RD_LAST) begin
                            state_d = HOLD_REPEAT;
                            hold_d  = '0;
                            step_d  = 1'b1;
                        end else if (hold_q != '1) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                HOLD_REPEAT: begin
                    if (repeat_en) begin
                        if (hold_q == RP_LAST) begin
                            hold_d = '0;
                            step_d = 1'b1;
                        end else if (hold_q != '1) begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HOLD_IDLE;
                    hold_d  = '0;
                end
            endcase
        end
    end

    assign btn_level   = level_q;
    assign btn_step    = step_q;
    assign btn_release = rel_q;

endmodule

// File: rtl/button_conditioner.sv
// Four independent button channels: {min_dec, min_inc, hour_dec, hour_inc}.
// Debounced levels, press/repeat steps and release pulses per button.
module button_conditioner
    import clock_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] btn_raw,
    input  logic       repeat_en,
    output logic [3:0] btn_level,
    output logic [3:0] btn_step,
    output logic [3:0] btn_release
);

    for (genvar i = 0; i < 4; i++) begin : g_ch
        button_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk         (clk),
            .rst_n       (rst_n),
            .btn_raw     (btn_raw[i]),
            .repeat_en   (repeat_en),
            .btn_level   (btn_level[i]),
            .btn_step    (btn_step[i]),
            .btn_release (btn_release[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: a window-based debounce/repeat model predicts every
// cycle's outputs; a monitor compares them against the DUT.
module tb_button_conditioner;

    localparam int DEB = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int HL  = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] btn_raw = 4'h0;
    logic       repeat_en = 1'b0;
    logic [3:0] btn_level;
    logic [3:0] btn_step;
    logic [3:0] btn_release;

    button_conditioner #(
        .DEBOUNCE_CYCLES (DEB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .repeat_en   (repeat_en),
        .btn_level   (btn_level),
        .btn_step    (btn_step),
        .btn_release (btn_release)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    logic [11:0] exp_q[$];
    logic [3:0]  hist[$];
    logic [3:0]  m_lvl = 4'h0;
    int          m_phase[4];
    int          m_e[4];

    function automatic void check(input string name,
                                  input logic [11:0] act,
                                  input logic [11:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s t=%0t actual lvl/step/rel=%03h required=%03h",
                      name, $time, act, req);
    endfunction

    // Model: a level flips once the last DEB synchronized samples all
    // disagree with it; steps come after RD enabled held cycles, then every RP.
    task automatic cycle(input logic [3:0] raw, input logic en,
                         input logic rst);
        logic [3:0] nl, st, rl;
        logic       prev_rst;
        int         L;
        @(negedge clk);
        prev_rst  = rst_n;
        btn_raw   = raw;
        repeat_en = en;
        rst_n     = rst;
        if (prev_rst && !rst) begin
            #1;
            check("reset_async", {btn_level, btn_step, btn_release}, 12'h0);
        end
        hist.push_back(rst ? raw : 4'h0);
        void'(hist.pop_front());
        L  = hist.size() - 1;
        nl = 4'h0;
        st = 4'h0;
        rl = 4'h0;
        if (rst) begin
            for (int ch = 0; ch < 4; ch++) begin
                logic flip;
                flip = 1'b1;
                for (int k = 2; k <= DEB + 1; k++)
                    if (hist[L-k][ch] == m_lvl[ch]) flip = 1'b0;
                nl[ch] = m_lvl[ch] ^ flip;
                if (m_lvl[ch] && !nl[ch]) begin
                    rl[ch] = 1'b1;
                    m_phase[ch] = 0;
                    m_e[ch] = 0;
                end else if (!m_lvl[ch] && nl[ch]) begin
                    st[ch] = 1'b1;
                    m_phase[ch] = 1;
                    m_e[ch] = 0;
                end else if (m_phase[ch] != 0 && en) begin
                    m_e[ch]++;
                    if (m_e[ch] == ((m_phase[ch] == 1) ? RD : RP)) begin
                        st[ch] = 1'b1;
                        m_e[ch] = 0;
                        m_phase[ch] = 2;
                    end
                end
            end
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                m_phase[ch] = 0;
                m_e[ch] = 0;
            end
        end
        m_lvl = nl;
        exp_q.push_back({nl, st, rl});
    endtask

    task automatic hold(input logic [3:0] raw, input logic en, input int n);
        for (int i = 0; i < n; i++) cycle(raw, en, 1'b1);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0)
                check("outputs", {btn_level, btn_step, btn_release},
                      exp_q.pop_front());
        end
    end

    initial begin
        logic [3:0] cur;
        int         rem[4];
        logic       en;
        for (int i = 0; i < HL; i++) hist.push_back(4'h0);
        for (int ch = 0; ch < 4; ch++) begin
            m_phase[ch] = 0;
            m_e[ch] = 0;
        end
        for (int i = 0; i < 3; i++) cycle(4'h0, 1'b0, 1'b0);
        hold(4'h0, 1'b0, 12);
        hold(4'b0001, 1'b0, 12);
        hold(4'h0, 1'b0, 14);
        for (int i = 0; i < 50; i++)
            cycle({2'b00, 1'((i / 3) % 2), 1'b0}, 1'b0, 1'b1);
        hold(4'h0, 1'b0, 14);
        hold(4'b0100, 1'b1, 70);
        hold(4'h0, 1'b1, 15);
        hold(4'b0100, 1'b0, 70);
        hold(4'h0, 1'b0, 15);
        hold(4'hF, 1'b1, 12);
        hold(4'h0, 1'b1, 14);
        hold(4'b1000, 1'b1, 40);
        for (int i = 0; i < 3; i++) cycle(4'b1000, 1'b1, 1'b0);
        hold(4'b1000, 1'b1, 30);
        hold(4'h0, 1'b1, 15);
        cur = 4'h0;
        en  = 1'b1;
        for (int ch = 0; ch < 4; ch++) rem[ch] = $urandom_range(1, 45);
        for (int i = 0; i < 3000; i++) begin
            for (int ch = 0; ch < 4; ch++) begin
                rem[ch]--;
                if (rem[ch] <= 0) begin
                    cur[ch] = ~cur[ch];
                    rem[ch] = $urandom_range(1, 45);
                end
            end
            if ($urandom_range(0, 49) == 0) en = ~en;
            if ($urandom_range(0, 799) == 0) begin
                for (int r = 0; r < 3; r++) cycle(cur, en, 1'b0);
            end else begin
                cycle(cur, en, 1'b1);
            end
        end
        @(posedge clk);
        #2;
        check("drain", {2'b00, 10'(exp_q.size())}, 12'h0);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
